// File: rtl/byte_serializer.sv
// -----------------------------------------------------------------------------
// byte_serializer
//
// Parallel-to-serial feeder for the serial sequence-detector stage. Words
// arrive over a valid/ready handshake, wait in a small circular FIFO and are
// then shifted out one bit per clock on data_out. A word that finishes its
// last bit is immediately followed by the next queued word, so bursts stream
// with no idle cycle. When nothing is queued the line rests at 0.
//
// Parameters
//   DATA_W    bits per word (>= 2)
//   DEPTH     FIFO entries, power of two, >= 2
//   MSB_FIRST 1: bit DATA_W-1 goes out first; 0: bit 0 goes out first
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   in_data      word to serialize
//   in_valid     in_data is valid this cycle
//   in_ready     FIFO has room (transfer on in_valid && in_ready)
//   data_out     registered serial bit
//   bit_valid    data_out carries a payload bit
//   frame_start  pulse with the first bit of every word
//   busy         shifter is in SHIFT
//   level        FIFO occupancy, not counting the word in the shifter
// -----------------------------------------------------------------------------
module byte_serializer #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     data_out,
  output logic                     bit_valid,
  output logic                     frame_start,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // FIFO storage and bookkeeping
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;

  // Shifter
  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              data_out_q, data_out_d;
  logic              bit_valid_q, bit_valid_d;
  logic              frame_start_q, frame_start_d;

  logic              push_s;
  logic              pop_s;
  logic              word_done_s;
  logic [DATA_W-1:0] head_s;

  // Bit that leaves the word first, honouring the configured order.
  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    if (MSB_FIRST) begin
      first_bit = w[DATA_W-1];
    end else begin
      first_bit = w[0];
    end
  endfunction

  // Word with its outgoing bit consumed, so the next bit sits in the exit slot.
  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
    if (MSB_FIRST) begin
      advance = {w[DATA_W-2:0], 1'b0};
    end else begin
      advance = {1'b0, w[DATA_W-1:1]};
    end
  endfunction

  assign in_ready    = (level_q != FULL_LVL);
  assign level       = level_q;
  assign data_out    = data_out_q;
  assign bit_valid   = bit_valid_q;
  assign frame_start = frame_start_q;
  assign busy        = (state_q == ST_SHIFT);

  // Handshake and pop decision: a pop only happens from IDLE or on the
  // last-bit boundary, so a word is never cut short.
  always_comb begin
    push_s      = in_valid && in_ready;
    word_done_s = (cnt_q == LAST_CNT);
    head_s      = mem_q[rd_ptr_q];
    if (level_q != {LVL_W{1'b0}}) begin
      pop_s = (state_q == ST_IDLE) || word_done_s;
    end else begin
      pop_s = 1'b0;
    end
  end

  // FIFO next state; pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    level_d = level_q + LVL_W'(push_s) - LVL_W'(pop_s);
  end

  // Shifter FSM next state and registered serial outputs.
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    cnt_d         = cnt_q;
    data_out_d    = 1'b0;
    bit_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pop_s) begin
          state_d       = ST_SHIFT;
          shreg_d       = advance(head_s);
          cnt_d         = CNT_W'(1);
          data_out_d    = first_bit(head_s);
          bit_valid_d   = 1'b1;
          frame_start_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end
      end
      ST_SHIFT: begin
        if (!word_done_s) begin
          shreg_d     = advance(shreg_q);
          cnt_d       = cnt_q + CNT_W'(1);
          data_out_d  = first_bit(shreg_q);
          bit_valid_d = 1'b1;
        end else if (pop_s) begin
          // Zero-gap hand-over to the next queued word.
          shreg_d       = advance(head_s);
          cnt_d         = CNT_W'(1);
          data_out_d    = first_bit(head_s);
          bit_valid_d   = 1'b1;
          frame_start_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State registers; reset discards queued words and any partial word at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
      wr_ptr_q      <= {PTR_W{1'b0}};
      rd_ptr_q      <= {PTR_W{1'b0}};
      level_q       <= {LVL_W{1'b0}};
      state_q       <= ST_IDLE;
      shreg_q       <= {DATA_W{1'b0}};
      cnt_q         <= {CNT_W{1'b0}};
      data_out_q    <= 1'b0;
      bit_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      cnt_q         <= cnt_d;
      data_out_q    <= data_out_d;
      bit_valid_q   <= bit_valid_d;
      frame_start_q <= frame_start_d;
    end
  end

endmodule

// File: tb/tb_byte_serializer.sv
// -----------------------------------------------------------------------------
// tb_byte_serializer
//
// Two instances share one stimulus stream: u_msb (MSB first) and u_lsb
// (LSB first). A queue-based reference model tracks accepted words, the word
// currently on the line and how many of its bits have been shown; every cycle
// both instances are compared against it, and scenario tasks add directed
// checks on the recovered bitstream.
// -----------------------------------------------------------------------------
module tb_byte_serializer;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int LVL_W  = $clog2(DEPTH) + 1;
  localparam int VEC_W  = 8 + 2 * LVL_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              rdy_m, dout_m, bv_m, fs_m, busy_m;
  logic [LVL_W-1:0]  lvl_m;
  logic              rdy_l, dout_l, bv_l, fs_l, busy_l;
  logic [LVL_W-1:0]  lvl_l;

  byte_serializer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_m), .data_out(dout_m), .bit_valid(bv_m),
    .frame_start(fs_m), .busy(busy_m), .level(lvl_m)
  );

  byte_serializer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_l), .data_out(dout_l), .bit_valid(bv_l),
    .frame_start(fs_l), .busy(busy_l), .level(lvl_l)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic [DATA_W-1:0] m_fifo[$];
  logic [DATA_W-1:0] m_cur;
  int                m_pos;   // bits of m_cur shown so far; 0 = line idle

  // Logs
  logic [DATA_W-1:0] sent_q[$];
  logic [DATA_W-1:0] rx_m[$];
  logic [DATA_W-1:0] rx_l[$];
  logic              hist_m[$];
  logic              hist_l[$];
  int                fs_hist[$];
  int                cyc;
  logic [DATA_W-1:0] mon_m, mon_l;
  int                mon_n;

  function automatic logic [VEC_W-1:0] obs_vec();
    return {dout_m, dout_l, bv_m, fs_m, busy_m, rdy_m, lvl_m,
            bv_l, fs_l, lvl_l};
  endfunction

  function automatic logic [VEC_W-1:0] exp_vec();
    logic eb_m, eb_l, act, first, rdy;
    logic [LVL_W-1:0] el;
    act   = (m_pos > 0);
    first = (m_pos == 1);
    eb_m  = 1'b0;
    eb_l  = 1'b0;
    if (act) begin
      eb_m = m_cur[DATA_W - m_pos];
      eb_l = m_cur[m_pos - 1];
    end
    el  = LVL_W'(m_fifo.size());
    rdy = (m_fifo.size() != DEPTH);
    return {eb_m, eb_l, act, first, act, rdy, el, act, first, el};
  endfunction

  task automatic clear_logs();
    sent_q.delete(); rx_m.delete(); rx_l.delete();
    hist_m.delete(); hist_l.delete(); fs_hist.delete();
    cyc = 0; mon_n = 0;
  endtask

  // One clock: advance the model over the rising edge, then collect outputs.
  task automatic step(output logic accepted);
    accepted = in_valid && (m_fifo.size() < DEPTH);
    @(posedge clk);
    if ((m_pos == 0 || m_pos == DATA_W) && m_fifo.size() > 0) begin
      m_cur = m_fifo.pop_front();
      m_pos = 1;
    end else if (m_pos == 0 || m_pos == DATA_W) begin
      m_pos = 0;
    end else begin
      m_pos = m_pos + 1;
    end
    if (accepted) begin
      m_fifo.push_back(in_data);
      sent_q.push_back(in_data);
    end
    @(negedge clk);
    cyc++;
    hist_m.push_back(dout_m);
    hist_l.push_back(dout_l);
    if (fs_m) fs_hist.push_back(cyc);
    if (bv_m) begin
      if (fs_m) begin
        mon_n = 0;
        mon_m = '0;
        mon_l = '0;
      end
      mon_m = {mon_m[DATA_W-2:0], dout_m};
      mon_l[mon_n] = dout_l;
      mon_n++;
      if (mon_n == DATA_W) begin
        rx_m.push_back(mon_m);
        rx_l.push_back(mon_l);
      end
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_pos = 0;
  endtask

  task automatic test_reset();
    logic [VEC_W-1:0] rst_exp;
    logic a;
    rst_exp = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, {LVL_W{1'b0}},
               1'b0, 1'b0, {LVL_W{1'b0}}};
    in_valid = 1'b0; in_data = '0; rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    model_reset();
    n_chk++;
    if (obs_vec() !== rst_exp) begin
      n_fail++;
      $display("FAIL reset_async obs=%b exp=%b", obs_vec(), rst_exp);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      step(a);
      n_chk++;
      if (obs_vec() !== rst_exp) begin
        n_fail++;
        $display("FAIL reset_idle cyc%0d obs=%b exp=%b", cyc, obs_vec(), rst_exp);
      end
    end
  endtask

  task automatic test_single();
    logic a;
    logic [DATA_W-1:0] bits;
    clear_logs();
    in_data = 8'hA5; in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(a);
      in_valid = 1'b0;
      n_chk++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL single cyc%0d obs=%b exp=%b", cyc, obs_vec(), exp_vec());
      end
    end
    bits = '0;
    for (int i = 1; i <= 8; i++) bits = {bits[DATA_W-2:0], hist_m[i]};
    n_chk++;
    if (bits !== 8'hA5 || fs_hist.size() != 1 || fs_hist[0] != 2) begin
      n_fail++;
      $display("FAIL single_stream bits=%h fs_count=%0d required bits=a5 one fs at cyc 2",
               bits, fs_hist.size());
    end
  endtask

  task automatic test_back_to_back();
    logic a;
    logic [15:0] bits;
    int hits;
    clear_logs();
    in_data = 8'h05; in_valid = 1'b1;
    for (int i = 0; i < 22; i++) begin
      step(a);
      if (i == 0) in_data = 8'h80;
      else in_valid = 1'b0;
      n_chk++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL b2b cyc%0d obs=%b exp=%b", cyc, obs_vec(), exp_vec());
      end
    end
    bits = '0;
    for (int i = 1; i <= 16; i++) bits = {bits[14:0], hist_m[i]};
    hits = 0;
    for (int i = 0; i + 2 < hist_m.size(); i++)
      if (hist_m[i] && !hist_m[i+1] && hist_m[i+2]) hits++;
    n_chk++;
    if (bits !== 16'h0580 || hits != 1) begin
      n_fail++;
      $display("FAIL b2b_stream bits=%h hits101=%0d required 0580 and 1", bits, hits);
    end
    n_chk++;
    if (fs_hist.size() != 2 || fs_hist[0] != 2 || fs_hist[1] != 10) begin
      n_fail++;
      $display("FAIL b2b_frame_start count=%0d required two pulses at cyc 2 and 10",
               fs_hist.size());
    end
  endtask

  task automatic test_backpressure();
    logic a;
    logic [DATA_W-1:0] w[6];
    int idx;
    bit full_seen;
    clear_logs();
    for (int k = 0; k < 6; k++) w[k] = {4'($urandom_range(0, 15)), 4'(k)};
    idx = 0; full_seen = 1'b0;
    in_valid = 1'b1; in_data = w[0];
    for (int i = 0; i < 70; i++) begin
      step(a);
      if (a) idx++;
      if (idx == 5 && a) begin
        full_seen = 1'b1;
        n_chk++;
        if ({rdy_m, lvl_m} !== {1'b0, LVL_W'(DEPTH)}) begin
          n_fail++;
          $display("FAIL bp_full ready=%b level=%0d required ready=0 level=%0d",
                   rdy_m, lvl_m, DEPTH);
        end
      end
      if (idx >= 6) in_valid = 1'b0;
      else in_data = w[idx];
      n_chk++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL bp cyc%0d obs=%b exp=%b", cyc, obs_vec(), exp_vec());
      end
    end
    n_chk++;
    if (!full_seen || rx_m.size() != 6) begin
      n_fail++;
      $display("FAIL bp_count words_out=%0d full_seen=%0d required 6 and 1",
               rx_m.size(), full_seen);
    end else begin
      for (int k = 0; k < 6; k++) begin
        n_chk++;
        if (rx_m[k] !== w[k]) begin
          n_fail++;
          $display("FAIL bp_order word%0d got=%h required=%h", k, rx_m[k], w[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_word();
    logic a;
    logic [DATA_W-1:0] bits;
    clear_logs();
    in_data = 8'hFF; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(a);
      if (i == 1) in_valid = 1'b0;
    end
    rst = 1'b0;
    #1;
    model_reset();
    n_chk++;
    if ({dout_m, dout_l, bv_m, busy_m, lvl_m} !== {1'b0, 1'b0, 1'b0, 1'b0, {LVL_W{1'b0}}}) begin
      n_fail++;
      $display("FAIL midreset_async dout=%b bv=%b busy=%b level=%0d required all 0",
               dout_m, bv_m, busy_m, lvl_m);
    end
    @(negedge clk);
    rst = 1'b1;
    clear_logs();
    for (int i = 0; i < 24; i++) begin
      if (i == 12) begin
        in_data = 8'h81; in_valid = 1'b1;
      end
      step(a);
      in_valid = 1'b0;
      n_chk++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL midreset cyc%0d obs=%b exp=%b", cyc, obs_vec(), exp_vec());
      end
    end
    bits = '0;
    for (int i = 13; i <= 20; i++) bits = {bits[DATA_W-2:0], hist_m[i]};
    n_chk++;
    if (rx_m.size() != 1 || bits !== 8'h81) begin
      n_fail++;
      $display("FAIL midreset_after words=%0d bits=%h required 1 word 81", rx_m.size(), bits);
    end
  endtask

  task automatic test_lsb_first();
    logic a;
    logic [DATA_W-1:0] bits;
    clear_logs();
    in_data = 8'h01; in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(a);
      in_valid = 1'b0;
      n_chk++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL lsb cyc%0d obs=%b exp=%b", cyc, obs_vec(), exp_vec());
      end
    end
    bits = '0;
    for (int i = 1; i <= 8; i++) bits = {bits[DATA_W-2:0], hist_l[i]};
    n_chk++;
    if (bits !== 8'h80 || rx_l.size() != 1) begin
      n_fail++;
      $display("FAIL lsb_stream bits=%h words=%0d required 80 (1,0,0,0,0,0,0,0) and 1",
               bits, rx_l.size());
    end
  endtask

  task automatic test_wrap_random();
    logic a;
    int max_lvl;
    int n_words;
    clear_logs();
    n_words = 3 * DEPTH;
    max_lvl = 0;
    for (int i = 0; i < 3000 && sent_q.size() < n_words; i++) begin
      in_data  = DATA_W'($urandom);
      in_valid = (sent_q.size() < n_words / 2) ? ($urandom_range(0, 1) == 0)
                                               : ($urandom_range(0, 11) == 0);
      step(a);
      if (int'(lvl_m) > max_lvl) max_lvl = int'(lvl_m);
      n_chk++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL wrap cyc%0d obs=%b exp=%b", cyc, obs_vec(), exp_vec());
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < (DEPTH + 2) * DATA_W; i++) step(a);
    n_chk++;
    if (sent_q.size() != n_words || rx_m.size() != n_words || rx_l.size() != n_words
        || max_lvl > DEPTH) begin
      n_fail++;
      $display("FAIL wrap_count sent=%0d rx=%0d rx_lsb=%0d max_level=%0d required %0d words level<=%0d",
               sent_q.size(), rx_m.size(), rx_l.size(), max_lvl, n_words, DEPTH);
    end else begin
      for (int k = 0; k < n_words; k++) begin
        n_chk++;
        if (rx_m[k] !== sent_q[k] || rx_l[k] !== sent_q[k]) begin
          n_fail++;
          $display("FAIL wrap_order word%0d msb=%h lsb=%h required=%h",
                   k, rx_m[k], rx_l[k], sent_q[k]);
        end
      end
    end
  endtask

  initial begin
    m_pos = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    test_lsb_first();
    test_wrap_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/byte_serializer.md
# byte_serializer

Upstream feeder for the serial sequence-detector stage. Accepts parallel bytes over a valid/ready handshake and buffers them in a small FIFO. Shifts them out one bit per clock onto a single serial line that drives the detector's `data_in`. Back-to-back bytes stream with no gap. The line idles at 0 so idle periods never create spurious patterns.

## Interface
Parameters:
- `DATA_W`, 8: bits per word.
- `DEPTH`, 4: FIFO entries; must be a power of two, ≥ 2.
- `MSB_FIRST`, 1: 1 = shift MSB first, 0 = LSB first.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low; clears all state immediately.
- `in_data`  in  DATA_W  word to serialize.
- `in_valid`  in  1  `in_data` is valid this cycle.
- `in_ready`  out  1  FIFO can accept a word; a transfer occurs on an edge where `in_valid && in_ready`.
- `data_out`  out  1  serial bit, registered; connects to the detector's `data_in`.
- `bit_valid`  out  1  `data_out` carries a payload bit this cycle.
- `frame_start`  out  1  one-cycle pulse coincident with the first bit of each word.
- `busy`  out  1  shifter state is SHIFT.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy, excluding the word in the shifter.

## Operation
- **Reset values:**
  - `data_out`=0, `bit_valid`=0, `frame_start`=0, `busy`=0.
  - `level`=0, `in_ready`=1.
  - FIFO pointers and bit counter cleared; state = IDLE.
- **FIFO:**
  - Circular buffer with read/write pointers and an occupancy counter.
  - `in_ready` = (`level` != DEPTH), combinational from registered `level`.
  - Push and pop on the same edge leave `level` unchanged.
  - A pop from a full FIFO does not raise `in_ready` until the following cycle.
  - Pointers wrap modulo DEPTH.
- **Shifter FSM, two states:**
  - IDLE:
    - If `level` > 0 at an edge: pop the head into the shift register and drive its first bit on `data_out`.
    - Same edge: `bit_valid`=1, `frame_start`=1, bit counter=1, state→SHIFT.
    - Otherwise `data_out`=0 and `bit_valid`=0.
  - SHIFT, bit counter < DATA_W: drive the next bit, increment the counter, `frame_start`=0.
  - SHIFT, bit counter == DATA_W and `level` > 0:
    - Pop the next word and drive its first bit.
    - `frame_start`=1, counter=1, stay in SHIFT (zero-gap streaming).
  - SHIFT, bit counter == DATA_W and FIFO empty: `data_out`=0, `bit_valid`=0, state→IDLE.
- **Bit order:**
  - MSB_FIRST=1: bit DATA_W-1 first, down to bit 0.
  - MSB_FIRST=0: bit 0 first, up to bit DATA_W-1.
- `busy` = (state == SHIFT); the shifter holds one word beyond the FIFO, so the block absorbs DEPTH+1 words before stalling.
- **Reset mid-operation:**
  - The partial word in the shifter and all FIFO contents are discarded.
  - `data_out` drops to 0 asynchronously; no remaining bits are emitted after release.

## Timing
- **Latency:** word accepted at edge k into an empty, idle block → first bit on `data_out` after edge k+1 (one cycle in the FIFO).
- **Word duration:** each word occupies exactly DATA_W consecutive cycles with `bit_valid`=1.
- **Streaming:** consecutive words in the FIFO produce a continuous bitstream; `frame_start` every DATA_W cycles.
- **Throughput:** one word per DATA_W cycles sustained; input bursts up to DEPTH+1 words without stall.
- **Pop timing:** a pop occurs only at the last-bit boundary or from IDLE, never mid-word.

## Test plan
- **Single word:** reset, push 0xA5 (MSB_FIRST=1).
  - `data_out` = 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting two edges after `rst` release plus push.
  - `bit_valid` high for exactly those 8 cycles; `frame_start` high on the first only; then `data_out`=0, `busy`=0.
- **Back-to-back:** push 0x05 then 0x80 on consecutive edges.
  - 16 contiguous bits 00000101 10000000, no idle cycle between them.
  - `frame_start` pulses 8 cycles apart; detector downstream asserts exactly once (on the 101 in 0x05).
- **Backpressure:** hold `in_valid` high with 6 distinct words from idle.
  - First 5 accepted; `in_ready` low with `level`=4.
  - Sixth accepted at the first edge after word 1 is popped.
  - Output order preserved: all 48 bits match.
- **Reset mid-word:** push 0xFF, 0xFF; pull `rst` low after 3 bits.
  - Immediately: `data_out`=0, `level`=0, `busy`=0.
  - After release: no further bits; the next pushed word 0x81 emits cleanly as 1,0,0,0,0,0,0,1.
- **LSB-first:** MSB_FIRST=0, push 0x01 → `data_out` = 1,0,0,0,0,0,0,0.
- **Wrap-around:** push/pop 3×DEPTH words with random gaps → every word emitted in order; `level` never exceeds DEPTH.
